// File: rtl/serial_tx.sv
// serial_tx: parallel-in, serial-out frame transmitter.
// Frame = start bit (0), WIDTH data bits LSB-first, stop bit (1); every bit
// is held for DIV clocks. One word is accepted per frame through load/ready.
// All outputs come straight from flops, so nothing on load/din reaches an
// output combinationally.
module serial_tx #(
    parameter int WIDTH = 8,
    parameter int DIV   = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] din,
    input  logic             load,
    output logic             ready,
    output logic             q,
    output logic             busy,
    output logic             done
);

    // Counter widths; the div counter keeps at least one bit so DIV=1 works.
    localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int BW = $clog2(WIDTH + 1);

    localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);
    localparam logic [DW-1:0] DIV_ONE  = DW'(1);
    localparam logic [BW-1:0] BIT_ONE  = BW'(1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_e;

    state_e           state_q, state_d;
    logic [DW-1:0]    div_q, div_d;
    logic [BW-1:0]    bit_q, bit_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic             q_q, q_d;
    logic             ready_q, ready_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic             div_wrap_s;
    logic [WIDTH-1:0] shift_next_s;

    // Last clock of the current bit period, and the word after one shift.
    assign div_wrap_s   = (div_q == DIV_LAST);
    assign shift_next_s = shift_q >> 1;

    // Next-state and next-output logic; outputs are computed one cycle early
    // so the registered value matches the state being entered.
    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        q_d     = q_q;
        ready_d = ready_q;
        busy_d  = busy_q;
        done_d  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (load && ready_q) begin
                    // Accepting edge: capture the word and drive the start bit.
                    state_d = S_START;
                    shift_d = din;
                    div_d   = '0;
                    bit_d   = '0;
                    q_d     = 1'b0;
                    ready_d = 1'b0;
                    busy_d  = 1'b1;
                end else begin
                    q_d     = 1'b1;
                    ready_d = 1'b1;
                    busy_d  = 1'b0;
                end
            end

            S_START: begin
                if (div_wrap_s) begin
                    div_d   = '0;
                    state_d = S_DATA;
                    q_d     = shift_q[0];
                end else begin
                    div_d   = div_q + DIV_ONE;
                end
            end

            S_DATA: begin
                if (div_wrap_s) begin
                    div_d   = '0;
                    shift_d = shift_next_s;
                    bit_d   = bit_q + BIT_ONE;
                    if (bit_q == BIT_LAST) begin
                        state_d = S_STOP;
                        q_d     = 1'b1;
                    end else begin
                        q_d     = shift_next_s[0];
                    end
                end else begin
                    div_d   = div_q + DIV_ONE;
                end
            end

            S_STOP: begin
                if (div_wrap_s) begin
                    // Frame complete: back to idle with a single done pulse.
                    div_d   = '0;
                    bit_d   = '0;
                    state_d = S_IDLE;
                    q_d     = 1'b1;
                    ready_d = 1'b1;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end else begin
                    div_d   = div_q + DIV_ONE;
                end
            end

            default: begin
                state_d = S_IDLE;
                div_d   = '0;
                bit_d   = '0;
                q_d     = 1'b1;
                ready_d = 1'b1;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State, counter, shift and output registers; reset forces an idle line.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            div_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            q_q     <= 1'b1;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            q_q     <= q_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign q     = q_q;
    assign ready = ready_q;
    assign busy  = busy_q;
    assign done  = done_q;

endmodule
